// File: rtl/cordic_arbiter_if.sv
// cordic_arbiter_if: bundles the requester, pipeline and response signals of cordic_arbiter.
// slave = arbiter view, master = environment (requesters + pipeline) view.
interface cordic_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                      a_req_valid;
  logic                      a_req_ready;
  logic                      a_req_arctan;
  logic [DATA_WIDTH-1:0]     a_req_operand;
  logic                      b_req_valid;
  logic                      b_req_ready;
  logic                      b_req_arctan;
  logic [DATA_WIDTH-1:0]     b_req_operand;

  logic                      pipe_valid_in;
  logic                      pipe_arctan_en;
  logic [DATA_WIDTH-1:0]     pipe_degree;
  logic [DATA_WIDTH-1:0]     pipe_tan;
  logic                      pipe_valid_out;
  logic [DATA_WIDTH-1:0]     pipe_x;
  logic [DATA_WIDTH-1:0]     pipe_y;
  logic [DATA_WIDTH-1:0]     pipe_degree_out;

  logic                      a_rsp_valid;
  logic                      a_rsp_ready;
  logic [3*DATA_WIDTH-1:0]   a_rsp_data;
  logic                      b_rsp_valid;
  logic                      b_rsp_ready;
  logic [3*DATA_WIDTH-1:0]   b_rsp_data;

  logic                      busy;
  logic                      err;

  modport slave (
    input  a_req_valid, a_req_arctan, a_req_operand,
    input  b_req_valid, b_req_arctan, b_req_operand,
    output a_req_ready, b_req_ready,
    output pipe_valid_in, pipe_arctan_en, pipe_degree, pipe_tan,
    input  pipe_valid_out, pipe_x, pipe_y, pipe_degree_out,
    output a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data,
    input  a_rsp_ready, b_rsp_ready,
    output busy, err
  );

  modport master (
    output a_req_valid, a_req_arctan, a_req_operand,
    output b_req_valid, b_req_arctan, b_req_operand,
    input  a_req_ready, b_req_ready,
    input  pipe_valid_in, pipe_arctan_en, pipe_degree, pipe_tan,
    output pipe_valid_out, pipe_x, pipe_y, pipe_degree_out,
    input  a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data,
    output a_rsp_ready, b_rsp_ready,
    input  busy, err
  );
endinterface

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one fixed-latency CORDIC pipeline between requesters A and B.
// Credit-gated round-robin issue, a tag shift register tracking result ownership,
// and one response FIFO per requester.
// Build option: define CORDIC_ARB_FIXED_PRIO_EN for strict A-over-B priority.
module cordic_arbiter #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned PIPE_LATENCY = 8,
  parameter int unsigned RESP_DEPTH   = 4
) (
  input logic             clk,
  input logic             reset,
  cordic_arbiter_if.slave bus
);
  localparam int unsigned RSP_W = 3 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Index 0 = requester A, index 1 = requester B.
  logic [1:0]            req_valid;
  logic [1:0]            req_arctan;
  logic [DATA_WIDTH-1:0] req_operand [2];
  logic [1:0]            rsp_ready;
  logic [1:0]            rsp_valid;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic [1:0]            pop;

  logic                  issue_arctan;
  logic [DATA_WIDTH-1:0] issue_operand;

  logic                  pipe_valid_q;
  logic                  pipe_id_q;
  logic                  pipe_arctan_q;
  logic [DATA_WIDTH-1:0] pipe_degree_q;
  logic [DATA_WIDTH-1:0] pipe_tan_q;

  logic [PIPE_LATENCY-1:0] tag_vld_q;
  logic [PIPE_LATENCY-1:0] tag_id_q;
  logic                    tag_last_vld;
  logic                    push_id;
  logic                    push_ok;
  logic                    overflow;

  logic [CNT_W-1:0] inflight_q [2];
  logic [CNT_W-1:0] inflight_d [2];
  logic [CNT_W-1:0] count_q    [2];
  logic [CNT_W-1:0] count_d    [2];
  logic [PTR_W-1:0] wr_ptr_q   [2];
  logic [PTR_W-1:0] rd_ptr_q   [2];
  logic [RSP_W-1:0] mem_q      [2][RESP_DEPTH];

  logic err_q;
  logic err_d;
  logic busy_q;
  logic busy_d;

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  logic last_q;  // 1 = B was granted most recently
`endif

  assign req_valid      = {bus.b_req_valid, bus.a_req_valid};
  assign req_arctan     = {bus.b_req_arctan, bus.a_req_arctan};
  assign req_operand[0] = bus.a_req_operand;
  assign req_operand[1] = bus.b_req_operand;
  assign rsp_ready      = {bus.b_rsp_ready, bus.a_rsp_ready};

  assign tag_last_vld = tag_vld_q[PIPE_LATENCY-1];
  assign push_id      = tag_id_q[PIPE_LATENCY-1];

  // Eligibility from registered credit, then a single grant per cycle
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] &&
                (SUM_W'(inflight_q[i]) + SUM_W'(count_q[i]) < SUM_W'(RESP_DEPTH));
    end
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    if (elig[0])      grant = 2'b01;
    else if (elig[1]) grant = 2'b10;
`else
    if (elig[0] && elig[1]) grant = last_q ? 2'b01 : 2'b10;
    else                    grant = elig;
`endif
    // Nothing is accepted while reset is held
    if (!reset) grant = '0;
  end

  assign issue_arctan  = req_arctan[grant[1]];
  assign issue_operand = req_operand[grant[1]];

  // Response-side events: retire into the owning FIFO and pops
  always_comb begin
    rsp_valid = '0;
    pop       = '0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (count_q[i] != '0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
    end
    overflow = bus.pipe_valid_out && tag_last_vld &&
               (count_q[push_id] == CNT_W'(RESP_DEPTH)) && !pop[push_id];
    push_ok  = bus.pipe_valid_out && tag_last_vld && !overflow;
  end

  // Next-state counters, sticky error and busy
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inflight_d[i] = inflight_q[i] + CNT_W'(grant[i])
                      - CNT_W'(push_ok && (push_id == 1'(i)));
      count_d[i]    = count_q[i] + CNT_W'(push_ok && (push_id == 1'(i)))
                      - CNT_W'(pop[i]);
      busy_d        = busy_d | (inflight_d[i] != '0) | (count_d[i] != '0);
    end
    err_d = err_q
          | (bus.pipe_valid_out && !tag_last_vld)
          | (tag_last_vld && !bus.pipe_valid_out)
          | overflow;
  end

`ifndef CORDIC_ARB_FIXED_PRIO_EN
  // Round-robin pointer: remembers the last granted requester
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      last_q <= 1'b1;
    else if (|grant) last_q <= grant[1];
  end
`endif

  // Pipeline input register stage; data fields hold when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_q  <= 1'b0;
      pipe_id_q     <= 1'b0;
      pipe_arctan_q <= 1'b0;
      pipe_degree_q <= '0;
      pipe_tan_q    <= '0;
    end else begin
      pipe_valid_q <= |grant;
      if (|grant) begin
        pipe_id_q     <= grant[1];
        pipe_arctan_q <= issue_arctan;
        pipe_degree_q <= issue_arctan ? '0 : issue_operand;
        pipe_tan_q    <= issue_arctan ? issue_operand : '0;
      end
    end
  end

  // Ownership tags, aligned so the last stage lines up with pipe_valid_out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      for (int s = PIPE_LATENCY - 1; s > 0; s--) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
      tag_vld_q[0] <= pipe_valid_q;
      tag_id_q[0]  <= pipe_id_q;
    end
  end

  // Counters, FIFO pointers, sticky error and busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        inflight_q[i] <= '0;
        count_q[i]    <= '0;
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
      end
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        inflight_q[i] <= inflight_d[i];
        count_q[i]    <= count_d[i];
        if (push_ok && (push_id == 1'(i))) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
      end
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  // Response storage (data only, validity lives in the counters)
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[push_id][wr_ptr_q[push_id]] <= {bus.pipe_x, bus.pipe_y, bus.pipe_degree_out};
    end
  end

  assign bus.a_req_ready    = grant[0];
  assign bus.b_req_ready    = grant[1];
  assign bus.pipe_valid_in  = pipe_valid_q;
  assign bus.pipe_arctan_en = pipe_arctan_q;
  assign bus.pipe_degree    = pipe_degree_q;
  assign bus.pipe_tan       = pipe_tan_q;
  assign bus.a_rsp_valid    = rsp_valid[0];
  assign bus.b_rsp_valid    = rsp_valid[1];
  assign bus.a_rsp_data     = mem_q[0][rd_ptr_q[0]];
  assign bus.b_rsp_data     = mem_q[1][rd_ptr_q[1]];
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: randomized bench for cordic_arbiter with a fake fixed-latency
// pipeline and a transaction-level model (credits as accepts minus pops, per-requester
// expected-response queues with due cycles).
module tb_cordic_arbiter;
  localparam int DW  = 16;
  localparam int L   = 8;
  localparam int RD  = 4;
  localparam int RW  = 3 * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic inject = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  cordic_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  cordic_arbiter #(.DATA_WIDTH(DW), .PIPE_LATENCY(L), .RESP_DEPTH(RD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in CORDIC: any deterministic function of operand and mode will do
  function automatic logic [RW-1:0] fake_cordic(input logic [DW-1:0] op, input logic m);
    logic [DW-1:0] x, y, d;
    x = op ^ 16'h5A5A;
    y = op + (m ? 16'd3 : 16'd1);
    d = ~op;
    return {x, y, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Fixed-latency pipeline model sharing the arbiter reset
  logic [L-1:0]  dly_vld;
  logic [RW-1:0] dly_dat [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld <= '0;
      for (int s = 0; s < L; s++) dly_dat[s] <= '0;
    end else begin
      for (int s = L - 1; s > 0; s--) begin
        dly_vld[s] <= dly_vld[s-1];
        dly_dat[s] <= dly_dat[s-1];
      end
      dly_vld[0] <= bus.pipe_valid_in;
      dly_dat[0] <= fake_cordic(bus.pipe_arctan_en ? bus.pipe_tan : bus.pipe_degree,
                                bus.pipe_arctan_en);
    end
  end
  assign bus.pipe_valid_out = dly_vld[L-1] | inject;
  assign bus.pipe_x          = dly_dat[L-1][3*DW-1:2*DW];
  assign bus.pipe_y          = dly_dat[L-1][2*DW-1:DW];
  assign bus.pipe_degree_out = dly_dat[L-1][DW-1:0];

  // Transaction-level model state
  typedef struct { logic [RW-1:0] data; int due; } exp_t;
  exp_t          qa[$];
  exp_t          qb[$];
  int            o_a = 0, o_b = 0;   // accepted minus popped
  bit            last_b = 1'b1;
  bit            prev_issue = 1'b0;
  bit            prev_mode = 1'b0;
  logic [DW-1:0] prev_op = '0;
  bit            exp_err = 1'b0;
  logic [1:0]    el, g;
  bit            va, vb;

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_a_req_ready", 64'(bus.a_req_ready), 64'd0);
      chk("rst_b_req_ready", 64'(bus.b_req_ready), 64'd0);
      chk("rst_pipe_valid_in", 64'(bus.pipe_valid_in), 64'd0);
      chk("rst_a_rsp_valid", 64'(bus.a_rsp_valid), 64'd0);
      chk("rst_b_rsp_valid", 64'(bus.b_rsp_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      qa.delete(); qb.delete();
      o_a = 0; o_b = 0; last_b = 1'b1; prev_issue = 1'b0; exp_err = 1'b0;
    end else begin
      el[0] = bus.a_req_valid && (o_a < RD);
      el[1] = bus.b_req_valid && (o_b < RD);
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      g = el[0] ? 2'b01 : (el[1] ? 2'b10 : 2'b00);
`else
      if (el[0] && el[1]) g = last_b ? 2'b01 : 2'b10;
      else                g = el;
`endif
      chk("a_req_ready", 64'(bus.a_req_ready), 64'(g[0]));
      chk("b_req_ready", 64'(bus.b_req_ready), 64'(g[1]));
      chk("pipe_valid_in", 64'(bus.pipe_valid_in), 64'(prev_issue));
      if (prev_issue) begin
        chk("pipe_arctan_en", 64'(bus.pipe_arctan_en), 64'(prev_mode));
        chk("pipe_degree", 64'(bus.pipe_degree), 64'(prev_mode ? 16'd0 : prev_op));
        chk("pipe_tan", 64'(bus.pipe_tan), 64'(prev_mode ? prev_op : 16'd0));
      end
      va = (qa.size() > 0) && (qa[0].due <= cyc);
      vb = (qb.size() > 0) && (qb[0].due <= cyc);
      chk("a_rsp_valid", 64'(bus.a_rsp_valid), 64'(va));
      chk("b_rsp_valid", 64'(bus.b_rsp_valid), 64'(vb));
      if (va) chk("a_rsp_data", 64'(bus.a_rsp_data), 64'(qa[0].data));
      if (vb) chk("b_rsp_data", 64'(bus.b_rsp_data), 64'(qb[0].data));
      chk("busy", 64'(bus.busy), 64'((o_a + o_b) != 0));
      chk("err", 64'(bus.err), 64'(exp_err));

      prev_issue = |g;
      if (g[0]) begin
        qa.push_back('{fake_cordic(bus.a_req_operand, bus.a_req_arctan), cyc + L + 2});
        o_a++; prev_op = bus.a_req_operand; prev_mode = bus.a_req_arctan; last_b = 1'b0;
      end else if (g[1]) begin
        qb.push_back('{fake_cordic(bus.b_req_operand, bus.b_req_arctan), cyc + L + 2});
        o_b++; prev_op = bus.b_req_operand; prev_mode = bus.b_req_arctan; last_b = 1'b1;
      end
      if (va && bus.a_rsp_ready) begin void'(qa.pop_front()); o_a--; end
      if (vb && bus.b_rsp_ready) begin void'(qb.pop_front()); o_b--; end
      if (inject) exp_err = 1'b1;
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input bit bv);
    bus.a_req_valid   = av;
    bus.b_req_valid   = bv;
    bus.a_req_operand = DW'($urandom);
    bus.b_req_operand = DW'($urandom);
    bus.a_req_arctan  = 1'($urandom);
    bus.b_req_arctan  = 1'($urandom);
  endtask

  task automatic do_reset();
    adv(1);
    rst_n = 1'b0;
    bus.a_req_valid = 1'b0;
    bus.b_req_valid = 1'b0;
    adv(2);
    rst_n = 1'b1;
  endtask

  int nb;

  initial begin
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b0;
    bus.a_req_arctan = 1'b0; bus.b_req_arctan = 1'b0;
    bus.a_req_operand = '0;  bus.b_req_operand = '0;
    bus.a_rsp_ready = 1'b1;  bus.b_rsp_ready = 1'b1;
    #2 rst_n = 1'b0;
    adv(3);
    rst_n = 1'b1;

    // Single rotate op from A: latency pins
    adv(1);
    bus.a_req_valid = 1'b1; bus.a_req_operand = 16'h2D00; bus.a_req_arctan = 1'b0;
    #2 chk("t1_a_req_ready_c0", 64'(bus.a_req_ready), 64'd1);
    adv(1);
    bus.a_req_valid = 1'b0;
    #2 chk("t1_pipe_valid_in_c1", 64'(bus.pipe_valid_in), 64'd1);
    chk("t1_pipe_degree_c1", 64'(bus.pipe_degree), 64'h2D00);
    chk("t1_pipe_tan_c1", 64'(bus.pipe_tan), 64'h0);
    adv(8);
    #2 chk("t1_a_rsp_valid_c9", 64'(bus.a_rsp_valid), 64'd0);
    adv(1);
    #2 chk("t1_a_rsp_valid_c10", 64'(bus.a_rsp_valid), 64'd1);
    chk("t1_a_rsp_data_c10", 64'(bus.a_rsp_data), 64'h775A_2D01_D2FF);
    chk("t1_err", 64'(bus.err), 64'd0);

    // Both requesters streaming, both responses always accepted
    do_reset();
    adv(1);
    drive(1, 1);
`ifndef CORDIC_ARB_FIXED_PRIO_EN
    #2 chk("rr_first_a", 64'({bus.b_req_ready, bus.a_req_ready}), 64'b01);
    adv(1);
    drive(1, 1);
    #2 chk("rr_then_b", 64'({bus.b_req_ready, bus.a_req_ready}), 64'b10);
`endif
    for (int k = 0; k < 40; k++) begin
      adv(1);
      drive(1, 1);
    end

    // B responses held off: B must stop after RD accepts
    do_reset();
    bus.b_rsp_ready = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      adv(1);
      drive(1'($urandom), 1);
      #2 if (bus.b_req_ready) nb++;
    end
    chk("b_accepts_when_blocked", 64'(nb), 64'(RD));
    adv(1);
    bus.a_req_valid = 1'b0;
    #2 chk("b_ready_still_blocked", 64'(bus.b_req_ready), 64'd0);
    adv(1);
    bus.b_rsp_ready = 1'b1;
    #2 chk("b_ready_at_pop", 64'(bus.b_req_ready), 64'd0);
    chk("b_rsp_valid_at_pop", 64'(bus.b_rsp_valid), 64'd1);
    adv(1);
    bus.b_rsp_ready = 1'b0;
    #2 chk("b_ready_after_pop", 64'(bus.b_req_ready), 64'd1);
    adv(1);
    #2 chk("b_ready_credit_used", 64'(bus.b_req_ready), 64'd0);
    bus.b_req_valid = 1'b0;
    bus.b_rsp_ready = 1'b1;

    // Spurious pipeline result raises a sticky error
    do_reset();
    adv(3);
    inject = 1'b1;
    #2 chk("inj_err_same_cycle", 64'(bus.err), 64'd0);
    adv(1);
    inject = 1'b0;
    #2 chk("inj_err_next_cycle", 64'(bus.err), 64'd1);
    adv(6);
    #2 chk("inj_err_sticky", 64'(bus.err), 64'd1);

    // Reset with three operations in flight
    do_reset();
    adv(1);
    drive(1, 1);
    adv(1);
    drive(1, 1);
    adv(1);
    drive(1, 0);
    adv(1);
    bus.a_req_valid = 1'b0;
    adv(1);
    rst_n = 1'b0;
    adv(2);
    rst_n = 1'b1;
    adv(1);
    #2 chk("rstfly_busy", 64'(bus.busy), 64'd0);
    chk("rstfly_a_rsp_valid", 64'(bus.a_rsp_valid), 64'd0);
    chk("rstfly_b_rsp_valid", 64'(bus.b_rsp_valid), 64'd0);
    chk("rstfly_err", 64'(bus.err), 64'd0);
    adv(L + 4);

    // Random traffic with random back-pressure
    for (int k = 0; k < 400; k++) begin
      adv(1);
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
      bus.a_rsp_ready = ($urandom_range(0, 9) < 6);
      bus.b_rsp_ready = ($urandom_range(0, 9) < 6);
    end
    adv(1);
    bus.a_req_valid = 1'b0; bus.b_req_valid = 1'b0;
    bus.a_rsp_ready = 1'b1; bus.b_rsp_ready = 1'b1;
    adv(L + 2 * RD + 10);
    #2 chk("drain_busy", 64'(bus.busy), 64'd0);
    chk("drain_err", 64'(bus.err), 64'd0);

    adv(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one CORDIC pipeline (rotate / arctan modes) between two requesters, A and B.
- Arbitrates issue slots round-robin and drives the pipeline input bundle from a register stage.
- Tracks which requester owns each in-flight operation with a tag shift register matched to the fixed pipeline latency.
- Returns each result into a per-requester response FIFO; issue is credit-gated so these FIFOs never overflow.

Parameters:
- DATA_WIDTH, 16, width of degree/tan operands and of x/y/degree results.
- PIPE_LATENCY, 8, cycles from pipe_valid_in high to the matching pipe_valid_out high; must be ≥1.
- RESP_DEPTH, 4, entries per response FIFO; must be a power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- a_req_valid / b_req_valid  in  1  requester has an operation
- a_req_ready / b_req_ready  out  1  operation accepted this cycle
- a_req_arctan / b_req_arctan  in  1  1 = arctan mode, 0 = rotate mode
- a_req_operand / b_req_operand  in  DATA_WIDTH  angle (rotate) or tan value (arctan)
- pipe_valid_in  out  1  issue strobe to the pipeline
- pipe_arctan_en  out  1  mode to the pipeline
- pipe_degree  out  DATA_WIDTH  operand when rotating; 0 in arctan mode
- pipe_tan  out  DATA_WIDTH  operand in arctan mode; 0 when rotating
- pipe_valid_out  in  1  pipeline result strobe
- pipe_x, pipe_y, pipe_degree_out  in  DATA_WIDTH each  pipeline results
- a_rsp_valid / b_rsp_valid  out  1  response FIFO non-empty
- a_rsp_ready / b_rsp_ready  in  1  requester pops the response
- a_rsp_data / b_rsp_data  out  3*DATA_WIDTH  {x, y, degree} at the FIFO head
- busy  out  1  any operation in flight or any response FIFO non-empty
- err  out  1  sticky protocol/tag error

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0; tags, counters and FIFOs cleared; round-robin pointer "last" = B, so A wins first. The pipeline shares this reset. Any operation in flight when reset asserts is dropped without error.
- Credit: credit_x = RESP_DEPTH − inflight_x − count_x, computed from registered values only. Eligible_x = x_req_valid && credit_x > 0.
- Grant (combinational):
  - If only one requester is eligible, it wins.
  - If both are eligible, the one that is not "last" wins.
  - x_req_ready = grant_x. At most one grant per cycle.
  - Ready never depends on rsp_ready in the same cycle; a pop frees credit the next cycle.
- Issue: on grant, the next clock edge registers pipe_valid_in=1, pipe_arctan_en, and the operand (routed to pipe_degree or pipe_tan by mode, the other field driven 0). "last" updates to the granted requester, and inflight_x increments. With no grant, pipe_valid_in=0 and the data fields hold their value. Accept-to-pipe_valid_in latency is 1 cycle; back-to-back issue every cycle is allowed.
- Tags: a PIPE_LATENCY-deep shift register of {valid, id} shifts every cycle; stage 0 loads {pipe_valid_in, id} at the edge where pipe_valid_in is launched. When the last stage is valid, pipe_valid_out must be 1 that cycle.
- Retire: on pipe_valid_out, {pipe_x, pipe_y, pipe_degree_out} is pushed into FIFO[id] and inflight[id] decrements.
- Total latency: accept to x_rsp_valid = PIPE_LATENCY + 2 cycles.
- FIFO: x_rsp_valid = !empty; pop on x_rsp_valid && x_rsp_ready. Push and pop in the same cycle keep count unchanged; push to an empty FIFO shows valid the next cycle. Pointers wrap modulo RESP_DEPTH.
- err is set and held until reset when any of these occur:
  - pipe_valid_out=1 while the last tag is invalid;
  - the last tag is valid while pipe_valid_out=0;
  - a push to a full FIFO.
  A push with an invalid tag is discarded.
- Simultaneous events: a retire and an issue for the same requester in one cycle leave inflight unchanged.
- busy = |inflight_a | inflight_b | count_a | count_b, registered.

Optional Feature:
- CORDIC_ARB_FIXED_PRIO_EN defined: A has strict priority whenever eligible; the "last" pointer is unused and B is granted only when A is not eligible.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then a_req_valid=1, operand=0x2D00, arctan=0 → a_req_ready=1 at cycle 0; pipe_valid_in=1 with pipe_degree=0x2D00, pipe_tan=0 at cycle 1; a_rsp_valid=1 at cycle PIPE_LATENCY+2 = 10 with the pipeline result; err=0.
- Both requesters valid continuously with both rsp_ready=1 → grants alternate A,B,A,B starting with A; every response returns to the correct port in order; 100% issue rate.
- b_rsp_ready=0, B requests continuously → exactly 4 B accepts, after which b_req_ready stays 0 while A continues to be served. Raising b_rsp_ready for one pop yields one new B accept the cycle after the pop.
- Pipeline model injects pipe_valid_out with no tag in flight → err rises the next cycle and stays 1 until reset.
- Reset pulse while 3 operations are in flight → busy=0 and no rsp_valid after reset release; err=0.
- With CORDIC_ARB_FIXED_PRIO_EN defined, both requesters valid → A granted every cycle until A is out of credit, then B is granted.
